upc_scanner: RTL and testbench
==============================

Name: upc_scanner

Overview:
Front-end capture stage for the store checkout display. Samples the 3-bit UPC switch bank when the scan button is pressed. Conditions the button with a synchronizer, debounce and single-fire logic. Forwards only legal item codes on a registered UPC bus to the downstream item-name display decoder, and keeps a saturating count of accepted scans.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles scan must be stable high (press) or low (release) to be accepted; minimum 1
COUNT_W, 4, width of the scan counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
upc_in  input  3  raw UPC switch value, treated as quasi-static
scan  input  1  raw scan button, active-high, asynchronous to clk, may bounce
UPC  output  3  registered accepted item code to the display decoder
upc_valid  output  1  one-cycle pulse when UPC is updated
upc_err  output  1  one-cycle pulse when a scan carried an illegal code
scan_count  output  COUNT_W  number of accepted scans, saturating
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: clk and reset are the only timing inputs. Reset is asynchronous and active-high.
  - Reset values: UPC=3'b000, upc_valid=0, upc_err=0, scan_count=0, FSM=IDLE.
  - Synchronizer flops reset to 0. Debounce counter resets to 0.
  - Reset asserted mid-operation aborts any pending capture. No pulse is emitted.
- Synchronizer: scan passes through 2 flops to give scan_s. Only scan_s is used internally. upc_in is not synchronized; it is sampled in CAPTURE only.
- Legal codes: 000, 001, 011, 100, 101, 110. Illegal codes: 010, 111.
- FSM states:
  - IDLE:
    - busy=0, debounce counter cleared.
    - scan_s=1 -> PRESS.
  - PRESS:
    - Counter increments each cycle scan_s=1.
    - scan_s=0 before the count is reached -> IDLE, counter cleared, no output.
    - Count reaches DEBOUNCE_CYCLES -> CAPTURE.
  - CAPTURE (exactly one cycle):
    - Samples upc_in.
    - Legal code: UPC<=upc_in, upc_valid=1 on the following cycle, scan_count increments unless it equals all-ones.
    - Illegal code: UPC holds its previous value, upc_err=1 on the following cycle, scan_count unchanged.
    - Unconditionally -> RELEASE.
  - RELEASE:
    - Counter increments each cycle scan_s=0. Any scan_s=1 clears the counter.
    - Count reaches DEBOUNCE_CYCLES -> IDLE.
    - Holding the button indefinitely produces no further captures.
- Latency: scan rising edge to upc_valid = 2 (sync) + DEBOUNCE_CYCLES + 1 (capture) + 1 (output register) cycles. For the default, this is 8 cycles from the first clk edge sampling scan high.
- upc_valid and upc_err are mutually exclusive and never high for more than one cycle per press.
- UPC never carries an illegal code, so the display decoder never sees an undefined case.
- An accepted code equal to the current UPC still pulses upc_valid and counts.
- scan_count saturates at 2^COUNT_W-1 and does not wrap.
- upc_in changes during PRESS or RELEASE have no effect. Only the CAPTURE-cycle value matters.

Test Plan:
1. Reset: assert reset mid-PRESS with scan held high -> all outputs return immediately to reset values, with no pulse. After reset deasserts with scan still high, a fresh full debounce is required before capture.
2. Clean press: upc_in=3'b101, scan high for 10 cycles then low -> one upc_valid pulse 8 cycles after scan is first sampled, UPC=101, scan_count=1, busy returns low after the release debounce.
3. Bounce: scan toggles 1,0,1,1,0 then stays high with upc_in=3'b011 -> no capture during the glitches, exactly one upc_valid, UPC=011. Bouncing on release causes no second capture.
4. Illegal codes: scan with upc_in=3'b010, then again with 3'b111, after a prior UPC=001 -> upc_err pulses twice, upc_valid never pulses, UPC stays 001, scan_count is unchanged.
5. Saturation: COUNT_W=4, perform 17 legal scans cycling through all six legal codes -> scan_count reaches 15 and holds, and each scan still pulses upc_valid with the correct UPC.
6. Hold and change: press and hold scan, change upc_in from 000 to 110 after capture -> UPC stays 000 with no further pulse until release completes and a new press occurs.

Source files
------------

// File: rtl/upc_scanner.sv
// upc_scanner: debounced scan-button capture of legal UPC codes onto a registered
// bus, with single-cycle valid/error pulses and a saturating accepted-scan count.
module upc_scanner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         upc_in,
    input  logic               scan,
    output logic [2:0]         UPC,
    output logic               upc_valid,
    output logic               upc_err,
    output logic [COUNT_W-1:0] scan_count,
    output logic               busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYCLES);
    typedef enum logic [1:0] {IDLE, PRESS, CAPTURE, RELEASE} state_t;
    state_t r_state, w_next;
    logic [1:0] r_sync;
    logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic w_scan_s, w_legal, w_take;
    assign w_scan_s = r_sync[1];
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_legal = upc_in != 3'b010 && upc_in != 3'b111;
    assign w_take = r_state == CAPTURE && w_legal;
    assign busy = r_state != IDLE;
    // The counter only ever runs while the synchronized level matches the state's goal.
    always_comb begin
        w_next = r_state;
        w_cnt_next = '0;
        case (r_state)
            IDLE: w_next = w_scan_s ? PRESS : IDLE;
            PRESS: begin
                w_next = !w_scan_s ? IDLE : (w_cnt_inc == DEB ? CAPTURE : PRESS);
                w_cnt_next = (w_scan_s && w_cnt_inc != DEB) ? w_cnt_inc : '0;
            end
            CAPTURE: w_next = RELEASE;
            RELEASE: begin
                w_next = (!w_scan_s && w_cnt_inc == DEB) ? IDLE : RELEASE;
                w_cnt_next = (!w_scan_s && w_cnt_inc != DEB) ? w_cnt_inc : '0;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_state <= IDLE;
            r_cnt <= '0;
            UPC <= '0;
            upc_valid <= 1'b0;
            upc_err <= 1'b0;
            scan_count <= '0;
        end else begin
            r_sync <= {r_sync[0], scan};
            r_state <= w_next;
            r_cnt <= w_cnt_next;
            upc_valid <= w_take;
            upc_err <= r_state == CAPTURE && !w_legal;
            if (w_take) UPC <= upc_in;
            if (w_take && scan_count != '1) scan_count <= scan_count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_upc_scanner.sv
// tb_upc_scanner: scoreboard bench; each press pushes its expected pulse, a
// negedge monitor pops and compares whenever the DUT pulses valid or err.
module tb_upc_scanner;
    localparam int DEB = 4;
    logic clk = 0, reset = 1, scan = 0;
    logic [2:0] upc_in = 3'd0;
    logic [2:0] UPC;
    logic upc_valid, upc_err, busy;
    logic [3:0] scan_count;
    int total = 0, bad = 0, cyc = 0, pulse_cyc = -1, start_cyc = 0;
    typedef struct packed {logic v; logic e; logic [2:0] upc; logic [3:0] cnt;} exp_t;
    exp_t q[$];
    logic [2:0] m_upc = 3'd0;
    int m_cnt = 0;

    upc_scanner #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(4)) dut (
        .clk(clk), .reset(reset), .upc_in(upc_in), .scan(scan), .UPC(UPC),
        .upc_valid(upc_valid), .upc_err(upc_err), .scan_count(scan_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (upc_valid || upc_err)) begin
            pulse_cyc = cyc;
            check("pulse_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) check("pulse_{v,e,upc,cnt}", int'({upc_valid, upc_err, UPC, scan_count}), int'(q.pop_front()));
        end
    end

    task automatic expect_scan(input logic [2:0] code);
        logic legal = code inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
        if (legal) begin
            m_upc = code;
            if (m_cnt < 15) m_cnt++;
        end
        q.push_back({legal, !legal, m_upc, 4'(m_cnt)});
    endtask

    function automatic logic [15:0] gen(input int n);
        logic [15:0] p = '0;
        int run = 0;
        for (int i = 0; i < n; i++) begin
            p[i] = (run < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            run = p[i] ? run + 1 : 0;
        end
        return p;
    endfunction

    task automatic press(input logic [2:0] code, input logic [15:0] pre, input int npre, input int hold,
                         input logic [15:0] post, input int npost, input int chg_at, input logic [2:0] chg_code);
        upc_in = code;
        for (int i = 0; i < npre; i++) begin
            scan = pre[i];
            @(negedge clk);
        end
        expect_scan(code);
        scan = 1;
        start_cyc = cyc;
        for (int i = 0; i < hold; i++) begin
            if (i == chg_at) upc_in = chg_code;
            @(negedge clk);
        end
        for (int i = 0; i < npost; i++) begin
            scan = post[i];
            @(negedge clk);
        end
        scan = 0;
        repeat (DEB + 6) @(negedge clk);
        check("busy_after_release", busy, 0);
        check("pending_pulses", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_UPC", UPC, 0);
        check("rst_valid", upc_valid, 0);
        check("rst_err", upc_err, 0);
        check("rst_count", scan_count, 0);
        check("rst_busy", busy, 0);
        reset = 0;
        @(negedge clk);
        press(3'b101, 0, 0, 10, 0, 0, -1, 0);
        check("latency_clean", pulse_cyc - start_cyc, 8);
        check("clean_UPC", UPC, 5);
        press(3'b011, 16'b01101, 5, 12, 16'b1010, 4, -1, 0);
        check("bounce_UPC", UPC, 3);
        press(3'b001, 0, 0, 10, 0, 0, -1, 0);
        press(3'b010, 0, 0, 10, 0, 0, -1, 0);
        press(3'b111, 0, 0, 10, 0, 0, -1, 0);
        check("illegal_UPC_held", UPC, 1);
        check("illegal_count", scan_count, 3);
        press(3'b000, 0, 0, 30, 0, 0, 10, 3'b110);
        check("hold_UPC", UPC, 0);
        press(3'b110, 0, 0, 10, 0, 0, -1, 0);
        check("after_hold_UPC", UPC, 6);
        upc_in = 3'd4;
        scan = 1;
        repeat (4) @(negedge clk);
        check("busy_in_press", busy, 1);
        reset = 1;
        #1;
        check("midrst_UPC", UPC, 0);
        check("midrst_count", scan_count, 0);
        check("midrst_valid", upc_valid, 0);
        check("midrst_err", upc_err, 0);
        check("midrst_busy", busy, 0);
        m_upc = 3'd0;
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        start_cyc = cyc;
        expect_scan(3'd4);
        repeat (12) @(negedge clk);
        scan = 0;
        repeat (DEB + 6) @(negedge clk);
        check("latency_after_reset", pulse_cyc - start_cyc, 8);
        check("pending_after_reset", q.size(), 0);
        for (int i = 0; i < 17; i++) begin
            logic [2:0] codes [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
            press(codes[i % 6], 0, 0, 10, 0, 0, -1, 0);
        end
        check("saturated_count", scan_count, 15);
        for (int i = 0; i < 30; i++) begin
            int npre = $urandom_range(0, 8);
            int npost = $urandom_range(0, 8);
            press(3'($urandom_range(0, 7)), gen(npre), npre, $urandom_range(10, 16),
                  gen(npost), npost, -1, 0);
        end
        check("final_UPC", UPC, m_upc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
